sys_regs: RTL
=============

Name: sys_regs

Overview:
- CPU-bus responder for the system control register window 0x2020–0x2027: joypad, IRQ timer, IRQ status/acknowledge, system control.
- The 65C02 and the DMA engine are the initiators on the system bus; this block is the target end for that address window.
- Replaces the combinational register latches in the top level with clocked registers.
- Exports the bank select, LCD enable and the combined IRQ line to the top level.

Parameters:
- PRESCALE_FAST, 256, timer tick period in cpu_ce pulses when sys_ctl[4]=0
- PRESCALE_SLOW, 16384, timer tick period in cpu_ce pulses when sys_ctl[4]=1

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous active-low reset
- cpu_ce  in  1  one-cycle strobe per CPU bus cycle; all bus side effects and timer counting are qualified by it
- cs  in  1  address decode hit for 0x2020–0x2027
- we  in  1  1 = write, 0 = read
- addr  in  3  register offset, AB[2:0]
- din  in  8  write data
- dout  out  8  read data, registered
- joy_n  in  8  joypad buttons, active-low
- dma_done  in  1  one-clk_sys pulse at DMA completion
- bank  out  2  sys_ctl[6:5], ROM bank for 0x8000–0xBFFF
- lcd_en  out  1  sys_ctl[3]
- irq  out  1  level IRQ to CPU
- nmi  out  1  NMI pulse; present only with the optional feature

Behaviour:
- Reset (reset_n=0 at an edge):
  - dout=0xFF, sys_ctl=0x00, timer=0x00, prescaler=0, irq_status=0.
  - Derived outputs follow: bank=0, lcd_en=0, irq=0, nmi=0.
- Access qualification:
  - An access takes effect only on an edge where cs & cpu_ce = 1.
  - Multi-cycle cs without cpu_ce causes no side effects.
- Read:
  - dout is loaded on the qualifying edge and is valid from the next clk_sys edge.
  - Offset 0 → joy_n.
  - Offset 3 → timer.
  - Offset 4 → 0xFF, and clears irq_status[0].
  - Offset 5 → 0xFF, and clears irq_status[1].
  - Offset 6 → sys_ctl.
  - Offset 7 → {6'b0, irq_status[1:0]}.
  - Offsets 1 and 2 → 0xFF.
  - Outside reads, dout holds its value.
- Write:
  - Offset 3 loads timer=din and clears the prescaler.
  - Offset 6 loads sys_ctl=din.
  - All other offsets are ignored.
  - Offsets 4 and 5 are read-only acknowledges; writes to them have no side effect.
- Timer:
  - Prescaler counts cpu_ce pulses.
  - It wraps to 0 after PRESCALE_FAST-1 or PRESCALE_SLOW-1, selected by sys_ctl[4] sampled each pulse.
  - Each wrap is a tick. On a tick with timer>0, timer decrements.
  - A decrement from 1 to 0 sets irq_status[0]. At timer=0, ticks do nothing; the timer does not wrap.
  - A write of 0 to offset 3 sets irq_status[0] on the same edge.
- IRQ:
  - dma_done sets irq_status[1].
  - irq = (irq_status[0] & sys_ctl[1]) | (irq_status[1] & sys_ctl[2]).
  - Status bits latch regardless of the enables, so enabling later raises irq immediately.
- Simultaneous events:
  - Set beats clear: an ack read on the same edge as a set (expiry or dma_done) leaves the bit at 1.
  - A timer write on the same edge as a tick: the write wins and the tick is discarded.
- Changing sys_ctl[4] mid-count:
  - The prescaler is not reset.
  - If its current count exceeds the new terminal value, it wraps on the next cpu_ce.
- Reset mid-count clears everything, with no pending irq.

Optional Feature:
- Macro: SYS_REGS_NMI_EN.
- Defined:
  - A 16-bit counter increments on each cpu_ce.
  - nmi=1 for one cpu_ce period when the counter wraps to 0, gated by sys_ctl[0].
  - The counter is cleared on reset.
- Undefined: nmi is tied to 0, the counter is absent, and sys_ctl[0] is plain storage.

Decomposition:
- Package sv_pkg:
  - Register offset constants: REG_JOY=3'd0, REG_TIMER=3'd3, REG_ACK_TIM=3'd4, REG_ACK_DMA=3'd5, REG_CTL=3'd6, REG_STAT=3'd7.
  - sys_ctl bit index constants: CTL_NMI=0, CTL_TIM_IE=1, CTL_DMA_IE=2, CTL_LCD=3, CTL_SLOW=4.
- One sub-module, sys_timer: prescaler, timer register and expiry pulse.

Test Plan:
- Reset, then read offset 6 and offset 0 with joy_n=0xA5 → dout 0x00, then 0xA5; irq=0, bank=0.
- Write ctl=0x02, write timer=3, apply 3·256 cpu_ce → timer reads 0, status reads 0x01, irq=1; read offset 4 → irq=0.
- Write ctl=0x12, timer=1 → no expiry at 256 cpu_ce; expiry at 16384 cpu_ce.
- dma_done pulse with ctl=0x00 → irq=0, status=0x02; write ctl=0x04 → irq=1 next edge; read offset 5 → 0.
- Ack read of offset 4 on the same edge as a timer 1→0 expiry → status bit0 stays 1.
- Write ctl=0x60 → bank=2'b11; write timer=0 → irq_status[0]=1 immediately.

Source files
------------

// File: rtl/sv_pkg.sv
// -----------------------------------------------------------------------------
// sv_pkg: shared constants for the system control register window (0x2020-0x2027).
//   - Register offsets within the window (AB[2:0]).
//   - Bit positions inside the sys_ctl register.
//   - Read value returned for unmapped and acknowledge offsets.
// -----------------------------------------------------------------------------
package sv_pkg;

  typedef logic [2:0] reg_off_t;

  // Register offsets
  localparam reg_off_t REG_JOY     = 3'd0;
  localparam reg_off_t REG_TIMER   = 3'd3;
  localparam reg_off_t REG_ACK_TIM = 3'd4;
  localparam reg_off_t REG_ACK_DMA = 3'd5;
  localparam reg_off_t REG_CTL     = 3'd6;
  localparam reg_off_t REG_STAT    = 3'd7;

  // sys_ctl bit positions
  localparam int CTL_NMI    = 0;
  localparam int CTL_TIM_IE = 1;
  localparam int CTL_DMA_IE = 2;
  localparam int CTL_LCD    = 3;
  localparam int CTL_SLOW   = 4;

  // Value driven for offsets that have no readable content
  localparam logic [7:0] RD_OPEN = 8'hFF;

endpackage

// File: rtl/sys_regs_timer.sv
// -----------------------------------------------------------------------------
// sys_timer: prescaled 8-bit down-counter for the IRQ timer.
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   synchronous active-low reset
//   cpu_ce    in   CPU bus-cycle strobe; the prescaler counts these
//   slow      in   selects PRESCALE_SLOW (1) or PRESCALE_FAST (0) tick period
//   load      in   load timer from load_val and clear prescaler (implies cpu_ce)
//   load_val  in   value for load
//   timer     out  current timer value
//   expire    out  combinational; high on the edge where the timer reaches 0
//                  (1->0 decrement or a load of 0)
// -----------------------------------------------------------------------------
module sys_timer #(
  parameter int PRESCALE_FAST = 256,
  parameter int PRESCALE_SLOW = 16384
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cpu_ce,
  input  logic       slow,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] timer,
  output logic       expire
);

  localparam int PS_MAX = (PRESCALE_SLOW > PRESCALE_FAST) ? PRESCALE_SLOW : PRESCALE_FAST;
  localparam int PW     = $clog2(PS_MAX);
  localparam logic [PW-1:0] TERM_FAST = PW'(PRESCALE_FAST - 1);
  localparam logic [PW-1:0] TERM_SLOW = PW'(PRESCALE_SLOW - 1);

  logic [PW-1:0] prescale_reg;
  logic [7:0]    timer_reg;
  logic [PW-1:0] term;
  logic          tick;

  // ">=" rather than "==" so that switching to the short period while the
  // count is already past its terminal value wraps on the very next pulse.
  always_comb begin
    term   = slow ? TERM_SLOW : TERM_FAST;
    tick   = cpu_ce && (prescale_reg >= term);
    // A load overrides any tick on the same edge, so only the load decides.
    expire = load ? (load_val == 8'd0) : (tick && (timer_reg == 8'd1));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prescale_reg <= '0;
      timer_reg    <= 8'd0;
    end else if (load) begin
      prescale_reg <= '0;
      timer_reg    <= load_val;
    end else if (cpu_ce) begin
      prescale_reg <= tick ? '0 : prescale_reg + 1'b1;
      // The timer parks at zero instead of wrapping.
      if (tick && (timer_reg != 8'd0))
        timer_reg <= timer_reg - 8'd1;
    end
  end

  assign timer = timer_reg;

endmodule

// File: rtl/sys_regs.sv
// -----------------------------------------------------------------------------
// sys_regs: CPU-bus target for the system control window 0x2020-0x2027
// (joypad, IRQ timer, IRQ status/acknowledge, system control).
// Ports:
//   clk_sys   in   system clock, all logic on its rising edge
//   reset_n   in   synchronous active-low reset
//   cpu_ce    in   one-cycle strobe per CPU bus cycle; qualifies all side effects
//   cs        in   window decode hit
//   we        in   1 = write, 0 = read
//   addr      in   register offset AB[2:0]
//   din       in   write data
//   dout      out  registered read data (valid the edge after the access)
//   joy_n     in   joypad buttons, active-low
//   dma_done  in   one-clock pulse at DMA completion
//   bank      out  sys_ctl[6:5]
//   lcd_en    out  sys_ctl[3]
//   irq       out  level IRQ
//   nmi       out  frame NMI pulse (only when SYS_REGS_NMI_EN is defined, else 0)
// Build option: define SYS_REGS_NMI_EN to add the 16-bit NMI frame counter.
// -----------------------------------------------------------------------------
module sys_regs
  import sv_pkg::*;
#(
  parameter int PRESCALE_FAST = 256,
  parameter int PRESCALE_SLOW = 16384
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cpu_ce,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] joy_n,
  input  logic       dma_done,
  output logic [1:0] bank,
  output logic       lcd_en,
  output logic       irq,
  output logic       nmi
);

  logic [7:0] dout_reg;
  logic [7:0] sys_ctl_reg;
  logic [1:0] irq_status_reg;
  logic [1:0] irq_status_next;
  logic [7:0] rd_data;
  logic [7:0] timer_val;
  logic       tim_expire;
  logic       acc_rd;
  logic       acc_wr;

  assign acc_rd = cs && cpu_ce && !we;
  assign acc_wr = cs && cpu_ce &&  we;

  sys_timer #(
    .PRESCALE_FAST (PRESCALE_FAST),
    .PRESCALE_SLOW (PRESCALE_SLOW)
  ) u_timer (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cpu_ce   (cpu_ce),
    .slow     (sys_ctl_reg[CTL_SLOW]),
    .load     (acc_wr && (addr == REG_TIMER)),
    .load_val (din),
    .timer    (timer_val),
    .expire   (tim_expire)
  );

  always_comb begin
    case (addr)
      REG_JOY:   rd_data = joy_n;
      REG_TIMER: rd_data = timer_val;
      REG_CTL:   rd_data = sys_ctl_reg;
      REG_STAT:  rd_data = {6'b0, irq_status_reg};
      default:   rd_data = RD_OPEN;
    endcase
  end

  // Acknowledge clears first, then sets, so a set on the same edge wins.
  always_comb begin
    irq_status_next = irq_status_reg;
    if (acc_rd && (addr == REG_ACK_TIM)) irq_status_next[0] = 1'b0;
    if (acc_rd && (addr == REG_ACK_DMA)) irq_status_next[1] = 1'b0;
    if (tim_expire)                      irq_status_next[0] = 1'b1;
    if (dma_done)                        irq_status_next[1] = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dout_reg       <= 8'hFF;
      sys_ctl_reg    <= 8'h00;
      irq_status_reg <= 2'b00;
    end else begin
      irq_status_reg <= irq_status_next;
      if (acc_rd)
        dout_reg <= rd_data;
      if (acc_wr && (addr == REG_CTL))
        sys_ctl_reg <= din;
    end
  end

  assign dout   = dout_reg;
  assign bank   = sys_ctl_reg[6:5];
  assign lcd_en = sys_ctl_reg[CTL_LCD];
  // Status latches independently of the enables, so enabling later fires at once.
  assign irq    = (irq_status_reg[0] & sys_ctl_reg[CTL_TIM_IE]) |
                  (irq_status_reg[1] & sys_ctl_reg[CTL_DMA_IE]);

`ifdef SYS_REGS_NMI_EN
  logic [15:0] frame_cnt_reg;
  logic        nmi_reg;

  // nmi is refreshed on every cpu_ce, so a wrap pulse lasts one cpu_ce period.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      frame_cnt_reg <= 16'd0;
      nmi_reg       <= 1'b0;
    end else if (cpu_ce) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
      nmi_reg       <= (frame_cnt_reg == 16'hFFFF) && sys_ctl_reg[CTL_NMI];
    end
  end

  assign nmi = nmi_reg;
`else
  assign nmi = 1'b0;
`endif

endmodule
